bus_slave: RTL and testbench



---
 rtl/bus_slave.sv | 173 +++++++++++++++++
 tb/tb_bus_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// bus_slave: one-wire serial bus slave endpoint.
// Matches a 2-bit ID and shifts in an address. A write then receives a data
// word and strobes it to the local module. A read waits for local data and
// shifts it back onto the bus. The shared busy line is held high while a
// transaction is in progress.
// Optional feature: define BUS_SLAVE_TIMEOUT_EN to abandon a wait for
// module_dv after 255 cycles.
module bus_slave #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter logic [1:0]  SELF_ID       = 2'b11
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     module_dv,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy,
  input  logic [DATA_WIDTH-1:0]    data_in_parellel,
  output logic                     write_en_internal,
  output logic [DATA_WIDTH-1:0]    data_out_parellel,
  output logic [ADDRESS_WIDTH-1:0] addr_buff
);

  localparam int unsigned MAX_W = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_WIDTH);

  // DSEL is the one-cycle direction-select slot after the last address bit
  typedef enum logic [3:0] {
    IDLE, ID, SKIP, ADDR, DSEL, WSTART, WDATA, WWAIT, RWAIT, RDATA
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     id_msb;
  logic [ADDRESS_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0]    data_sr;
  logic                     sd_oe;
  logic                     sd_out;
  logic                     busy_q;
  logic                     serial_in;

`ifdef BUS_SLAVE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;
  logic [7:0] wait_cnt;
`endif

  // Open-drain style bus lines: drive only when owned, otherwise release
  assign serial_in       = data_bus_serial;
  assign data_bus_serial = sd_oe ? sd_out : 1'bz;
  assign slave_busy      = busy_q ? 1'b1 : 1'bz;

  // Frame sequencer with registered strobe, bus drive and busy outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      id_msb            <= 1'b0;
      addr_sr           <= '0;
      data_sr           <= '0;
      addr_buff         <= '0;
      data_out_parellel <= '0;
      write_en_internal <= 1'b0;
      sd_oe             <= 1'b0;
      sd_out            <= 1'b1;
      busy_q            <= 1'b0;
`ifdef BUS_SLAVE_TIMEOUT_EN
      wait_cnt          <= '0;
`endif
    end else begin
      write_en_internal <= 1'b0;
      case (state)
        IDLE: begin
          if (bus_util && !serial_in) begin
            state   <= ID;
            bit_cnt <= '0;
          end
        end
        ID: begin
          id_msb  <= serial_in;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt != '0) begin
            bit_cnt <= '0;
            state   <= ({id_msb, serial_in} == SELF_ID) ? ADDR : SKIP;
          end
        end
        SKIP: begin
          if (!bus_util) state <= IDLE;
        end
        ADDR: begin
          addr_sr <= {addr_sr[ADDRESS_WIDTH-2:0], serial_in};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == ADDR_LAST) begin
            addr_buff <= {addr_sr[ADDRESS_WIDTH-2:0], serial_in};
            state     <= DSEL;
          end
        end
        DSEL: begin
          busy_q  <= 1'b1;
          bit_cnt <= '0;
`ifdef BUS_SLAVE_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state   <= rd_wrt ? RWAIT : WSTART;
        end
        WSTART: begin
          if (!serial_in) begin
            state   <= WDATA;
            bit_cnt <= '0;
          end
        end
        WDATA: begin
          data_sr <= {data_sr[DATA_WIDTH-2:0], serial_in};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == DATA_LAST) begin
            data_out_parellel <= {data_sr[DATA_WIDTH-2:0], serial_in};
            write_en_internal <= 1'b1;
            state             <= WWAIT;
          end
        end
        WWAIT: begin
          if (module_dv) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
`ifdef BUS_SLAVE_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RWAIT: begin
          if (module_dv) begin
            data_sr <= data_in_parellel;
            sd_oe   <= 1'b1;
            sd_out  <= 1'b0;
            bit_cnt <= '0;
            state   <= RDATA;
          end
`ifdef BUS_SLAVE_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        RDATA: begin
          if (bit_cnt == DATA_END) begin
            sd_oe  <= 1'b0;
            sd_out <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            sd_out  <= data_sr[DATA_WIDTH-1];
            data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_slave.sv
// tb_bus_slave: directed stimulus with queue-based scoreboard for bus_slave.
// Expected write strobes and read bits are queued by the stimulus thread and
// popped by a monitor whenever the DUT strobes a write or drives the bus.
module tb_bus_slave;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rd_wrt;
  logic          bus_util;
  logic          module_dv;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;
  logic [AW-1:0] addr;
  wire           data_bus_serial;
  wire           slave_busy;
  logic          tb_drive;
  logic          tb_sd;

  int n_tests   = 0;
  int n_fail    = 0;
  int wr_pulses = 0;

  wr_exp_t wr_q[$];
  logic    rd_q[$];

  always #5 clk = ~clk;

  assign data_bus_serial = tb_drive ? tb_sd : 1'bz;

  bus_slave #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .SELF_ID(2'b11)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rd_wrt(rd_wrt),
    .bus_util(bus_util),
    .module_dv(module_dv),
    .data_bus_serial(data_bus_serial),
    .slave_busy(slave_busy),
    .data_in_parellel(din),
    .write_en_internal(we),
    .data_out_parellel(dout),
    .addr_buff(addr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare whenever the DUT strobes a write or drives the bus
  always @(negedge clk) begin
    wr_exp_t e;
    logic    eb;
    if (rstn === 1'b1 && we === 1'b1) begin
      wr_pulses++;
      if (wr_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = wr_q.pop_front();
        check("wr_addr", {17'b0, addr}, {17'b0, e.a});
        check("wr_data", {24'b0, dout}, {24'b0, e.d});
      end
    end
    if (tb_drive === 1'b0 && data_bus_serial !== 1'bz) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected_drive", 32'd1, 32'd0);
      end else begin
        eb = rd_q.pop_front();
        check("rd_bit", {31'b0, data_bus_serial}, {31'b0, eb});
      end
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    tb_sd = b;
  endtask

  task automatic send_hdr(input logic [1:0] id, input logic [AW-1:0] a);
    send_bit(1'b0);
    send_bit(id[1]);
    send_bit(id[0]);
    for (int unsigned i = 0; i < AW; i++) send_bit(a[AW-1-i]);
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    for (int unsigned i = 0; i < DW; i++) send_bit(d[DW-1-i]);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rv;
    int            busy_cnt;

    rstn = 1'b0; rd_wrt = 1'b0; bus_util = 1'b0; module_dv = 1'b0;
    din = '0; tb_drive = 1'b1; tb_sd = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_dout", {24'b0, dout}, 32'd0);
    check("rst_addr", {17'b0, addr}, 32'd0);
    check("rst_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    @(posedge clk); #1 tb_drive = 1'b0;
    @(negedge clk);
    check("rst_bus_z", {31'b0, (data_bus_serial === 1'bz)}, 32'd1);
    @(posedge clk); #1 tb_drive = 1'b1;

    // Reset released mid-frame: block must stay idle
    bus_util = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    rstn = 1'b1;
    repeat (5) send_bit(1'b1);
    bus_util = 1'b0;
    send_bit(1'b1);
    check("midrst_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("midrst_addr", {17'b0, addr}, 32'd0);

    // module_dv in IDLE is ignored
    @(negedge clk); module_dv = 1'b1;
    @(negedge clk); module_dv = 1'b0;
    @(negedge clk);
    check("dv_idle_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);

    // Write: addr 1234, data A5
    bus_util = 1'b1; rd_wrt = 1'b0;
    send_hdr(2'b11, 15'h1234);
    send_bit(1'b1);
    check("wr_addr_buff", {17'b0, addr}, 32'h1234);
    check("wr_dsel_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    bus_util = 1'b0;
    send_bit(1'b1);
    check("wr_wstart_busy", {31'b0, (slave_busy === 1'b1)}, 32'd1);
    send_bit(1'b1);
    wr_q.push_back({15'h1234, 8'hA5});
    send_bit(1'b0);
    send_data(8'hA5);
    @(negedge clk); tb_sd = 1'b1;
    check("we_high", {31'b0, we}, 32'd1);
    @(negedge clk);
    check("we_one_cycle", {31'b0, we}, 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wr_wwait_busy", {31'b0, (slave_busy === 1'b1)}, 32'd1);
    end
    module_dv = 1'b1;
    @(negedge clk); module_dv = 1'b0;
    check("wr_busy_released", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("wr_dout_hold", {24'b0, dout}, 32'hA5);

    // Read: addr 0042, data 3C returned after 300 ns
    bus_util = 1'b1; rd_wrt = 1'b1; din = 8'h3C;
    send_hdr(2'b11, 15'h0042);
    @(posedge clk); #1 tb_drive = 1'b0;
    bus_util = 1'b0;
    for (int unsigned k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k > 0) check("rd_wait_busy", {31'b0, (slave_busy === 1'b1)}, 32'd1);
    end
    check("rd_addr_buff", {17'b0, addr}, 32'h0042);
    rv = 8'h3C;
    rd_q.push_back(1'b0);
    for (int unsigned i = 0; i < DW; i++) rd_q.push_back(rv[DW-1-i]);
    module_dv = 1'b1;
    @(negedge clk); module_dv = 1'b0;
    for (int unsigned k = 0; k < 20 && rd_q.size() != 0; k++) @(posedge clk);
    check("rd_drained", rd_q.size(), 32'd0);
    rd_q.delete();
    @(negedge clk);
    check("rd_bus_released", {31'b0, (data_bus_serial === 1'bz)}, 32'd1);
    check("rd_busy_released", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("rd_dout_untouched", {24'b0, dout}, 32'hA5);
    @(posedge clk); #1 tb_sd = 1'b1; tb_drive = 1'b1;

    // Wrong ID: skip until bus_util drops
    bus_util = 1'b1;
    send_hdr(2'b01, 15'h0000);
    check("wid_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    bus_util = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("wid_addr_unchanged", {17'b0, addr}, 32'h0042);
    check("wid_busy_z_after", {31'b0, (slave_busy === 1'bz)}, 32'd1);

    // Start qualification: full frame shape with bus_util low is ignored
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    for (int unsigned i = 0; i < AW; i++) send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    check("sq_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("sq_addr_unchanged", {17'b0, addr}, 32'h0042);

    // Boundary write: all-ones address, LSB-only data, immediate start bit
    bus_util = 1'b1; rd_wrt = 1'b0;
    send_hdr(2'b11, 15'h7FFF);
    send_bit(1'b1);
    check("wr2_addr_buff", {17'b0, addr}, 32'h7FFF);
    bus_util = 1'b0;
    wr_q.push_back({15'h7FFF, 8'h01});
    send_bit(1'b0);
    send_data(8'h01);
    @(negedge clk); tb_sd = 1'b1;
    @(negedge clk); module_dv = 1'b1;
    @(negedge clk); module_dv = 1'b0;
    check("wr2_busy_released", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("wr2_dout", {24'b0, dout}, 32'h01);
    check("wr_pulse_count", wr_pulses, 32'd2);

    // Reset mid-transaction aborts immediately
    bus_util = 1'b1; rd_wrt = 1'b1;
    send_hdr(2'b11, 15'h0001);
    @(posedge clk); #1 tb_drive = 1'b0;
    bus_util = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'b0, (slave_busy === 1'b1)}, 32'd1);
    rstn = 1'b0;
    #1;
    check("abort_busy_z", {31'b0, (slave_busy === 1'bz)}, 32'd1);
    check("abort_bus_z", {31'b0, (data_bus_serial === 1'bz)}, 32'd1);
    check("abort_addr", {17'b0, addr}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1 tb_sd = 1'b1; tb_drive = 1'b1;

`ifdef BUS_SLAVE_TIMEOUT_EN
    // Timeout: read with no module_dv releases busy after 255 cycles
    bus_util = 1'b1; rd_wrt = 1'b1;
    send_hdr(2'b11, 15'h0005);
    @(posedge clk); #1 tb_drive = 1'b0;
    bus_util = 1'b0;
    busy_cnt = 0;
    for (int unsigned k = 0; k < 400; k++) begin
      @(negedge clk);
      if (slave_busy === 1'b1) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    check("timeout_busy_cycles", busy_cnt, 32'd255);
    check("timeout_bus_z", {31'b0, (data_bus_serial === 1'bz)}, 32'd1);
    @(posedge clk); #1 tb_sd = 1'b1; tb_drive = 1'b1;
`else
    busy_cnt = 0;
`endif

    @(negedge clk);
    check("wr_queue_empty", wr_q.size(), 32'd0);
    check("wr_pulse_final", wr_pulses, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
